// File: rtl/mx_block_pair_assembler.sv
// mx_block_pair_assembler: assembles lane-parallel MX operand beats into complete A/B block pairs
// Ports: clk, rst_n (async active-low); input beat in_valid/in_ready/in_first, in_scale_a/b,
// in_elem_a/b (LANES elements); output pair out_valid/out_ready, scale_a/b, elements_a/b
// (BLOCK_SIZE elements), block_id (16-bit sequence number); err is a sticky protocol error.
module mx_block_pair_assembler #(
    parameter int BLOCK_SIZE  = 32,
    parameter int ELEM_WIDTH  = 8,
    parameter int SCALE_WIDTH = 8,
    parameter int LANES       = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_first,
    input  logic [SCALE_WIDTH-1:0]           in_scale_a,
    input  logic [SCALE_WIDTH-1:0]           in_scale_b,
    input  logic [LANES*ELEM_WIDTH-1:0]      in_elem_a,
    input  logic [LANES*ELEM_WIDTH-1:0]      in_elem_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SCALE_WIDTH-1:0]           scale_a,
    output logic [SCALE_WIDTH-1:0]           scale_b,
    output logic [BLOCK_SIZE*ELEM_WIDTH-1:0] elements_a,
    output logic [BLOCK_SIZE*ELEM_WIDTH-1:0] elements_b,
    output logic [15:0]                      block_id,
    output logic                             err
);
    localparam int BEATS = BLOCK_SIZE / LANES;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int LW    = LANES * ELEM_WIDTH;
    localparam int VW    = BLOCK_SIZE * ELEM_WIDTH;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                 state, state_n;
    logic [BW-1:0]          beat_cnt, beat_n, idx;
    logic [1:0]             count;
    logic                   wr_ptr, rd_ptr;
    logic [15:0]            next_id;
    logic [SCALE_WIDTH-1:0] sa_buf [2];
    logic [SCALE_WIDTH-1:0] sb_buf [2];
    logic [VW-1:0]          ea_buf [2];
    logic [VW-1:0]          eb_buf [2];
    logic [15:0]            id_buf [2];
    logic                   accept, pop, orphan, restart, write, complete;

    assign in_ready   = count != 2'd2;
    assign out_valid  = count != 2'd0;
    assign scale_a    = sa_buf[rd_ptr];
    assign scale_b    = sb_buf[rd_ptr];
    assign elements_a = ea_buf[rd_ptr];
    assign elements_b = eb_buf[rd_ptr];
    assign block_id   = id_buf[rd_ptr];

    // A first beat always lands at beat 0, which also covers restarting a partial block in place.
    always_comb begin
        accept   = in_valid && in_ready;
        pop      = out_valid && out_ready;
        orphan   = accept && !in_first && state == IDLE;
        restart  = accept && in_first && state == FILL;
        write    = accept && !orphan;
        idx      = in_first ? '0 : beat_cnt;
        complete = write && idx == BW'(BEATS - 1);
        state_n  = complete ? IDLE : write ? FILL : state;
        beat_n   = complete ? '0 : write ? idx + 1'b1 : beat_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            count    <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            next_id  <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_n;
            count    <= count + 2'(complete) - 2'(pop);
            wr_ptr   <= wr_ptr ^ complete;
            rd_ptr   <= rd_ptr ^ pop;
            next_id  <= next_id + 16'(complete);
            err      <= err | orphan | restart;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                sa_buf[i] <= '0;
                sb_buf[i] <= '0;
                ea_buf[i] <= '0;
                eb_buf[i] <= '0;
                id_buf[i] <= '0;
            end
        end else if (write) begin
            if (in_first) begin
                sa_buf[wr_ptr] <= in_scale_a;
                sb_buf[wr_ptr] <= in_scale_b;
            end
            ea_buf[wr_ptr][int'(idx)*LW +: LW] <= in_elem_a;
            eb_buf[wr_ptr][int'(idx)*LW +: LW] <= in_elem_b;
            if (complete)
                id_buf[wr_ptr] <= next_id;
        end
    end
endmodule

// File: tb/tb_mx_block_pair_assembler.sv
// tb_mx_block_pair_assembler: randomized and directed check of the block pair assembler against a queue model
module tb_mx_block_pair_assembler;
    localparam int BS = 32, EW = 8, SW = 8, L = 4, BEATS = BS / L, LW = L * EW, VW = BS * EW;

    typedef struct {
        logic [SW-1:0] sa, sb;
        logic [VW-1:0] ea, eb;
        logic [15:0]   id;
    } pair_t;

    logic          clk = 0, rst_n = 0, in_valid = 0, in_first = 0, out_ready = 0;
    logic          in_ready, out_valid, err;
    logic [SW-1:0] in_scale_a = 0, in_scale_b = 0, scale_a, scale_b;
    logic [LW-1:0] in_elem_a = 0, in_elem_b = 0;
    logic [VW-1:0] elements_a, elements_b;
    logic [15:0]   block_id;
    int            tests = 0, fails = 0, cyc = 0, t0;
    bit            rnd_on = 0;

    pair_t         q[$];
    pair_t         np;
    bit            m_act = 0, m_err = 0, acc, pp;
    int            m_beats = 0;
    logic [15:0]   m_id = 0;
    logic [SW-1:0] m_sa, m_sb;
    logic [VW-1:0] m_ea, m_eb;

    mx_block_pair_assembler #(.BLOCK_SIZE(BS), .ELEM_WIDTH(EW), .SCALE_WIDTH(SW), .LANES(L)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
        .in_scale_a(in_scale_a), .in_scale_b(in_scale_b), .in_elem_a(in_elem_a), .in_elem_b(in_elem_b),
        .out_valid(out_valid), .out_ready(out_ready), .scale_a(scale_a), .scale_b(scale_b),
        .elements_a(elements_a), .elements_b(elements_b), .block_id(block_id), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Model: a queue of completed pairs; inputs are stable from posedge+1 to the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_act = 0; m_err = 0; m_beats = 0; m_id = 0;
        end else begin
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, q.size() < 2);
            chk("err", err, m_err);
            if (q.size() > 0) begin
                chk("scale_a", scale_a, q[0].sa);
                chk("scale_b", scale_b, q[0].sb);
                chk("elements_a", elements_a, q[0].ea);
                chk("elements_b", elements_b, q[0].eb);
                chk("block_id", block_id, q[0].id);
            end
            acc = in_valid && q.size() < 2;
            pp  = q.size() > 0 && out_ready;
            if (pp) void'(q.pop_front());
            if (acc) begin
                if (in_first) begin
                    if (m_act) m_err = 1;
                    m_act = 1; m_beats = 0; m_sa = in_scale_a; m_sb = in_scale_b;
                end else if (!m_act) m_err = 1;
                if (m_act) begin
                    m_ea[m_beats*LW +: LW] = in_elem_a;
                    m_eb[m_beats*LW +: LW] = in_elem_b;
                    m_beats++;
                    if (m_beats == BEATS) begin
                        np.sa = m_sa; np.sb = m_sb; np.ea = m_ea; np.eb = m_eb; np.id = m_id;
                        q.push_back(np);
                        m_id++;
                        m_act = 0;
                    end
                end
            end
        end
    end

    task automatic send_beat(input bit first, input logic [SW-1:0] sa, input logic [SW-1:0] sb,
                             input logic [LW-1:0] ea, input logic [LW-1:0] eb);
        int w = 0;
        bit r;
        in_valid = 1; in_first = first; in_scale_a = sa; in_scale_b = sb; in_elem_a = ea; in_elem_b = eb;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            w++;
        end while (!r && w < 500);
        if (!r) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 500 cycles");
        end
        in_valid = 0;
    endtask

    task automatic send_block(input logic [SW-1:0] sa, input logic [SW-1:0] sb, input int nb,
                              input bit pat, input bit gaps);
        logic [LW-1:0] ea, eb;
        int i;
        for (int k = 0; k < nb; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            for (int l = 0; l < L; l++) begin
                i = k * L + l;
                ea[l*EW +: EW] = pat ? 8'(i) : 8'($urandom);
                eb[l*EW +: EW] = pat ? 8'(-i) : 8'($urandom);
            end
            send_beat(k == 0, sa, sb, ea, eb);
        end
    endtask

    task automatic do_reset();
        in_valid = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_err", err, 0);
        chk("rst_block_id", block_id, 0);
        chk("rst_scale_a", scale_a, 0);
        chk("rst_elements_a", elements_a, 0);
        chk("rst_elements_b", elements_b, 0);
        rst_n = 1;

        out_ready = 1;
        send_block(127, 130, BEATS, 1, 0);
        chk("single_valid", out_valid, 1);
        chk("single_scale_a", scale_a, 127);
        chk("single_scale_b", scale_b, 130);
        chk("single_id", block_id, 0);
        chk("single_err", err, 0);
        chk("single_a31", elements_a[31*EW +: EW], 31);
        chk("single_a0", elements_a[0 +: EW], 0);
        chk("single_b5", elements_b[5*EW +: EW], 8'hFB);
        @(posedge clk);
        #1;
        chk("single_popped", out_valid, 0);

        do_reset();
        out_ready = 1;
        t0 = cyc;
        repeat (4) send_block(8'($urandom), 8'($urandom), BEATS, 0, 0);
        chk("sustained_cycles", cyc - t0, 32);
        chk("sustained_last_id", block_id, 3);
        chk("sustained_valid", out_valid, 1);

        do_reset();
        out_ready = 0;
        fork
            repeat (3) send_block(8'($urandom), 8'($urandom), BEATS, 0, 0);
            begin
                repeat (20) @(posedge clk);
                #1;
                chk("bp_in_ready", in_ready, 0);
                chk("bp_valid", out_valid, 1);
                chk("bp_id", block_id, 0);
                out_ready = 1;
            end
        join
        chk("bp_third_id", block_id, 2);
        chk("bp_third_valid", out_valid, 1);

        do_reset();
        out_ready = 1;
        send_block(9, 9, 4, 0, 0);
        send_block(5, 7, BEATS, 0, 0);
        chk("restart_err", err, 1);
        chk("restart_valid", out_valid, 1);
        chk("restart_scale_a", scale_a, 5);
        chk("restart_id", block_id, 0);

        do_reset();
        out_ready = 1;
        send_beat(0, 1, 1, LW'($urandom), LW'($urandom));
        chk("orphan_err", err, 1);
        chk("orphan_valid", out_valid, 0);
        send_block(3, 4, BEATS, 0, 0);
        chk("orphan_next_id", block_id, 0);
        chk("orphan_next_valid", out_valid, 1);

        do_reset();
        out_ready = 0;
        send_beat(0, 1, 1, LW'($urandom), LW'($urandom));
        send_block(11, 12, BEATS, 0, 0);
        send_block(13, 14, 3, 0, 0);
        rst_n = 0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_err", err, 0);
        chk("midrst_scale_a", scale_a, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        out_ready = 1;
        send_block(21, 22, BEATS, 0, 0);
        chk("midrst_next_id", block_id, 0);
        chk("midrst_next_scale", scale_a, 21);

        do_reset();
        rnd_on = 1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1;
                out_ready = $urandom_range(0, 1);
            end
        join_none
        for (int b = 0; b < 60; b++) begin
            case ($urandom_range(0, 9))
                0: send_beat(0, 8'($urandom), 8'($urandom), LW'($urandom), LW'($urandom));
                1: send_block(8'($urandom), 8'($urandom), $urandom_range(1, BEATS - 1), 0, 1);
                default: ;
            endcase
            send_block(8'($urandom), 8'($urandom), BEATS, 0, 1);
        end
        rnd_on = 0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("drained", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mx_block_pair_assembler.md
# mx_block_pair_assembler

Streams two MX operand blocks (A and B) in over a narrow lane-parallel bus and assembles them into complete block pairs (shared scales plus BLOCK_SIZE elements each) for the MXINT8 dot-product datapath. It is the parametrised, synthesizable successor to the file-driven stimulus path. It adds a valid/ready handshake on both sides, configurable element width, block size and lane count, and a two-entry ping-pong buffer so input streaming continues while the consumer stalls. It sits between the operand fetch stream and the dot-product unit.

## Interface
- BLOCK_SIZE, 32: elements per MX block; must be a multiple of LANES.
- ELEM_WIDTH, 8: element width in bits.
- SCALE_WIDTH, 8: shared-scale width in bits.
- LANES, 4: elements per operand per input beat; BEATS = BLOCK_SIZE/LANES.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_first  in  1  beat is beat 0 of a block; scales sampled only on such beats.
- in_scale_a, in_scale_b  in  SCALE_WIDTH  shared scales.
- in_elem_a, in_elem_b  in  LANES*ELEM_WIDTH  lane l occupies bits [l*ELEM_WIDTH +: ELEM_WIDTH].
- out_valid  out  1  complete block pair available.
- out_ready  in  1  consumer takes the pair.
- scale_a, scale_b  out  SCALE_WIDTH  scales of the presented pair.
- elements_a, elements_b  out  BLOCK_SIZE*ELEM_WIDTH  element i at [i*ELEM_WIDTH +: ELEM_WIDTH].
- block_id  out  16  sequence number of the presented pair; wraps 0xFFFF->0.
- err  out  1  sticky protocol error; cleared only by reset.

## Operation
- Beat accepted when in_valid && in_ready. Pair popped when out_valid && out_ready.
- Two buffers. wr_ptr selects the buffer being filled. rd_ptr selects the presented buffer. count holds 0..2 complete buffers.
- Fill FSM, IDLE:
  - Accepted beat with in_first: latch scales, write lanes to elements 0..LANES-1, beat_cnt=1, go to FILL.
  - Accepted beat without in_first: drop it, set err, stay in IDLE.
- Fill FSM, FILL:
  - Accepted beat without in_first: write lanes to elements beat_cnt*LANES+l, then beat_cnt++.
  - When the final beat (beat_cnt=BEATS-1) is written: mark the buffer complete, count++, toggle wr_ptr, tag the buffer with the next id, go to IDLE.
  - Accepted beat with in_first in FILL: discard the partial block, set err, and restart the fill with this beat as beat 0 of the same buffer. No id is consumed.
- If BEATS==1, every beat completes a block; a beat without in_first is an error as in IDLE.
- in_ready = (count<2). It is a function of registered state only; there is no combinational path from out_ready.
- out_valid = (count>0). Outputs are driven from buffer[rd_ptr]. Pop sets count-- and toggles rd_ptr.
- Completion and pop in the same cycle: count unchanged, both pointers toggle.
- block_id counter starts at 0 and increments per completed block; it is stored with each buffer.
- Outputs hold stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync deassert):
  - out_valid=0, in_ready=1, err=0, block_id=0.
  - scale_a/b=0, elements_a/b=0.
  - FSM=IDLE, count=0, pointers=0, beat_cnt=0.
- Latency: out_valid rises the cycle after the final beat is accepted.
- Throughput: one beat per cycle sustained with out_ready high. One pair every BEATS cycles; in_ready never drops.
- With out_ready low: two pairs buffered. in_ready falls the cycle after the second completion and rises the cycle after the first pop.
- Reset mid-fill or mid-stall: all partial and buffered data is lost; state returns to reset values.

## Test plan
(BLOCK_SIZE=32, LANES=4, BEATS=8)
- Single block: scales 127/130, a[i]=i, b[i]=-i, 8 back-to-back beats, out_ready=1 -> out_valid 1 cycle after beat 8; scale_a=127, scale_b=130; elements exact; block_id=0; err=0.
- Backpressure: out_ready=0, stream 3 blocks -> in_ready low after 16 beats. Then raise out_ready -> ids 0,1 pop in order, block 2 accepted, id 2 presented.
- Sustained: out_ready=1, 4 blocks back-to-back (32 beats) -> in_ready constantly 1; out_valid pulses at cycles 9,17,25,33; ids 0..3.
- Restart: in_first reasserted on beat 5 with scale_a=5 -> err=1; the first 4 beats are discarded; the pair completes 8 beats later with scale_a=5 and id 0.
- Orphan beat: beat with in_first=0 in IDLE -> accepted and dropped, err=1, no out_valid; the next well-formed block completes with id 0.
- Reset mid-fill after 3 beats, plus one buffered pair -> out_valid=0, in_ready=1, err=0 immediately; the next block gets id 0.
